// File: rtl/bus_pkg.sv
// Shared definitions for the two-master bus arbiter.
// Holds the FSM encoding, the counter widths and the grant decoder.
package bus_pkg;

  localparam int HOLD_W = 8;
  localparam int TURN_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_e;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between two bus masters and the arbiter.
// The arbiter uses the slave modport; the requesting side uses master.
interface bus_arbiter_if;
   logic [1:0] i_req;
   logic [1:0] o_grant;
   logic       o_owner;
   logic       o_busy;

   modport slave  (input  i_req, output o_grant, output o_owner, output o_busy);
   modport master (output i_req, input  o_grant, input  o_owner, input  o_busy);
endinterface

// File: rtl/bus_arbiter_rr_pick2.sv
// Combinational round-robin choice between two requesters.
// On contention the master that did not own the bus last wins.
module rr_pick2 (
   input  logic [1:0] req_i,
   input  logic       last_owner_i,
   output logic       valid_o,
   output logic       index_o
);

   always_comb begin
      // NOTE: every output gets a default first, so no path through the
      // block leaves a value unassigned and no latch is inferred.
      valid_o = |req_i;
      index_o = last_owner_i;
      case (req_i)
         2'b01:   index_o = 1'b0;
         2'b10:   index_o = 1'b1;
         2'b11:   index_o = ~last_owner_i;
         default: index_o = last_owner_i;
      endcase
   end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter with a guaranteed idle turnaround between owners.
// Define BUS_ARB_TIMEOUT_EN to preempt an owner after MAX_HOLD grant cycles.
module bus_arbiter
   import bus_pkg::*;
#(
   parameter int TURNAROUND = 1,
   parameter int MAX_HOLD   = 8
) (
   input  logic          i_clk,
   input  logic          reset,
   bus_arbiter_if.slave  bus
);

`ifdef BUS_ARB_TIMEOUT_EN
   localparam bit TIMEOUT_EN = 1'b1;
`else
   localparam bit TIMEOUT_EN = 1'b0;
`endif

   localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURNAROUND - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   arb_state_e        state_q;
   logic [1:0]        grant_q;
   logic              owner_q;
   logic [HOLD_W-1:0] hold_q;
   logic [TURN_W-1:0] turn_q;

   logic pick_valid;
   logic pick_idx;
   logic preempt;

   rr_pick2 u_pick (
      .req_i        (bus.i_req),
      .last_owner_i (owner_q),
      .valid_o      (pick_valid),
      .index_o      (pick_idx)
   );

   // Preemption only fires when the waiting master is actually requesting.
   assign preempt = TIMEOUT_EN && (hold_q == HOLD_LAST) && bus.i_req[~owner_q];

   // NOTE: all state here is sequential, so it is written only with
   // non-blocking assignments to avoid ordering races between flops.
   always_ff @(posedge i_clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         grant_q <= 2'b00;
         owner_q <= 1'b1;
         hold_q  <= '0;
         turn_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pick_valid) begin
                  state_q <= GRANT;
                  grant_q <= onehot2(pick_idx);
                  owner_q <= pick_idx;
                  hold_q  <= '0;
               end
            end
            GRANT: begin
               if (preempt || !bus.i_req[owner_q]) begin
                  state_q <= TURN;
                  grant_q <= 2'b00;
                  turn_q  <= '0;
               end else if (hold_q != '1) begin
                  hold_q <= hold_q + 1'b1;
               end
            end
            TURN: begin
               if (turn_q == TURN_LAST) begin
                  if (pick_valid) begin
                     state_q <= GRANT;
                     grant_q <= onehot2(pick_idx);
                     owner_q <= pick_idx;
                     hold_q  <= '0;
                  end else begin
                     state_q <= IDLE;
                  end
               end else begin
                  turn_q <= turn_q + 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               grant_q <= 2'b00;
            end
         endcase
      end
   end

   assign bus.o_grant = grant_q;
   assign bus.o_owner = owner_q;
   assign bus.o_busy  = |grant_q;

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter TURNAROUND, default 1, meaning: idle cycles (all enables low) between successive bus owners; legal range 1..15.
REQ-002 Parameter MAX_HOLD, default 8, meaning: maximum consecutive grant cycles when the other master is waiting; legal range 2..255.
REQ-003 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 i_req  input  2  per-master bus request; bit n belongs to master n.
REQ-006 o_grant  output  2  registered, one-hot-or-zero drive enable; bit n gates master n's tri-state driver onto the shared 8-bit bus.
REQ-007 o_owner  output  1  index of the current owner, or of the most recent owner while no grant is active.
REQ-008 o_busy  output  1  high whenever o_grant is non-zero.

Function
REQ-009 FSM states SHALL be IDLE, GRANT and TURN.
REQ-010 IDLE: if i_req is non-zero, the next state is GRANT and the corresponding o_grant bit is set on that edge (1-cycle latency); otherwise the FSM stays in IDLE.
REQ-011 Selection when both requests are high SHALL be round-robin: the master that is not o_owner wins; when one request is high, that master wins.
REQ-012 GRANT: while the owner's i_req stays high, the grant is held and the 8-bit hold counter increments, saturating at 255.
REQ-013 GRANT: when the owner's i_req is low, the FSM SHALL move to TURN and clear o_grant on that edge.
REQ-014 TURN: o_grant = 2'b00 for exactly TURNAROUND cycles, counted by a 4-bit counter.
REQ-015 TURN exit: if i_req is non-zero, go to GRANT using REQ-011; otherwise go to IDLE.
REQ-016 o_grant SHALL never be 2'b11.
REQ-017 o_grant SHALL never change directly from one master to the other without at least TURNAROUND cycles at 2'b00 in between.
REQ-018 If the owner drops and re-raises i_req during TURN, the owner is re-granted only if the other master is not requesting at TURN exit.
REQ-019 o_owner SHALL update on the same edge that a new grant is issued.
REQ-020 Requests from a master whose grant bit is low SHALL NOT affect the current grant except through REQ-024.

Reset
REQ-021 While reset is low: state = IDLE, o_grant = 2'b00, o_busy = 0, o_owner = 1 (so master 0 wins the first contention), all counters = 0.
REQ-022 Reset asserted mid-grant SHALL clear o_grant asynchronously, without waiting for a clock edge.
REQ-023 After reset deasserts, the first grant SHALL follow REQ-010 with no extra turnaround.

Configuration
REQ-024 With BUS_ARB_TIMEOUT_EN defined, the grant SHALL be preempted when the hold counter reaches MAX_HOLD-1 and the other master's i_req is high: the FSM moves to TURN and the other master is granted at TURN exit.
REQ-025 Without BUS_ARB_TIMEOUT_EN, there is no preemption: the owner keeps the bus until its i_req drops, and the hold counter need not be implemented.

Structure
REQ-026 Shared package bus_pkg SHALL hold: state encoding, hold-counter width (8) and turnaround-counter width (4).
REQ-027 The round-robin choice SHALL be a separate combinational sub-module rr_pick2 (inputs: req[1:0], last owner; outputs: valid, index).

Verification
REQ-028 Reset low with i_req=2'b11 -> o_grant=00; release reset -> o_grant=01 one cycle later, o_owner=0.
REQ-029 Master 0 holds i_req for 5 cycles then drops it, with i_req[1] high throughout and TURNAROUND=1 -> grant 01 for 5 cycles, 00 for 1 cycle, then 10.
REQ-030 BUS_ARB_TIMEOUT_EN, MAX_HOLD=4, both requests held continuously -> grant pattern 01 x4, 00, 10 x4, 00, 01, repeating.
REQ-031 Same stimulus as REQ-030 without BUS_ARB_TIMEOUT_EN -> 01 held indefinitely and 10 never asserted.
REQ-032 TURNAROUND=3, single requester pulses i_req[0] for 1 cycle twice, 2 cycles apart -> second grant is separated from the first by exactly 3 zero cycles.
REQ-033 Reset pulsed low mid-grant, between clock edges -> o_grant=00 immediately; every cycle of every test: o_grant != 11.
